// File: rtl/audio_tone_pkg.sv
// Shared types and constants for the game tone sequencer: event codes, note records,
// the fixed note table and the tone word layout.
package audio_tone_pkg;

    typedef enum logic [1:0] {
        EvHit      = 2'd0,
        EvWall     = 2'd1,
        EvScore    = 2'd2,
        EvReserved = 2'd3
    } event_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StHold,
        StSilence
    } state_e;

    typedef struct packed {
        logic [19:0] half_period;
        logic [7:0]  dur_ms;
    } note_t;

    localparam int unsigned NUM_EVENTS      = 3;
    localparam int unsigned NOTES_PER_EVENT = 4;

    localparam int unsigned TONE_EN_BIT   = 31;
    localparam int unsigned HALF_PERIOD_W = 20;
    localparam logic [31:0] TONE_SILENCE  = 32'h0000_0000;

    // A zero duration terminates a sequence early.
    localparam note_t NOTE_TABLE [NUM_EVENTS][NOTES_PER_EVENT] = '{
        '{ '{20'd56818, 8'd30}, '{20'd0, 8'd0}, '{20'd0, 8'd0}, '{20'd0, 8'd0} },
        '{ '{20'd113636, 8'd40}, '{20'd0, 8'd0}, '{20'd0, 8'd0}, '{20'd0, 8'd0} },
        '{ '{20'd47801, 8'd80}, '{20'd37936, 8'd80}, '{20'd31888, 8'd160}, '{20'd0, 8'd0} }
    };

    function automatic logic [1:0] event_prio(event_e e);
        case (e)
            EvHit:   return 2'd1;
            EvWall:  return 2'd2;
            EvScore: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic note_t note_lookup(event_e e, logic [1:0] idx);
        if (e == EvReserved) begin
            return '0;
        end
        return NOTE_TABLE[int'(e)][int'(idx)];
    endfunction

    function automatic logic [31:0] tone_word(logic [HALF_PERIOD_W-1:0] half_period);
        logic [31:0] w;
        w                      = TONE_SILENCE;
        w[TONE_EN_BIT]         = 1'b1;
        w[HALF_PERIOD_W-1:0]   = half_period;
        return w;
    endfunction

endpackage

// File: rtl/audio_ms_tick.sv
// Duration prescaler: pulses tick once every DIV cycles while clear is low.
// Held at zero whenever clear is high, so counting always starts fresh.
module audio_ms_tick #(
    parameter int unsigned DIV = 50_000
) (
    input  logic clock50,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick = !clear && (cnt_q == LAST);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_tone_master.sv
// Avalon-MM write master that plays per-event note sequences into the audio peripheral,
// ending each sequence with a silence write; higher-priority events preempt lower ones.
module audio_tone_master
    import audio_tone_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic        clock50,
    input  logic        reset,
    input  logic        trig_valid,
    input  logic [1:0]  trig_event,
    output logic        busy,
    output logic        done,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    state_e      state_q, state_d;
    event_e      cur_evt_q, cur_evt_d;
    event_e      pend_evt_q, pend_evt_d;
    logic        pend_valid_q, pend_valid_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] tone_q, tone_d;
    logic [7:0]  dur_q, dur_d;
    logic [7:0]  dur_cnt_q, dur_cnt_d;
    logic        done_q, done_d;

    event_e      trig_evt, eff_evt, ref_evt;
    logic [2:0]  eff_idx;
    note_t       note;
    logic        tick, presc_clear, consume, preempt, wr_done, hold_done;

    audio_ms_tick #(
        .DIV(DIV)
    ) u_ms_tick (
        .clock50(clock50),
        .reset  (reset),
        .clear  (presc_clear),
        .tick   (tick)
    );

    // LOAD swaps in a pending event in place, so preemption costs no extra cycle.
    always_comb begin
        trig_evt    = event_e'(trig_event);
        consume     = (state_q == StLoad) && pend_valid_q;
        eff_evt     = consume ? pend_evt_q : cur_evt_q;
        eff_idx     = consume ? 3'd0 : idx_q;
        note        = note_lookup(eff_evt, eff_idx[1:0]);
        ref_evt     = pend_valid_q ? pend_evt_q : cur_evt_q;
        preempt     = trig_valid && (trig_evt != EvReserved) && (state_q != StIdle) &&
                      (event_prio(trig_evt) > event_prio(ref_evt));
        wr_done     = !avm_waitrequest;
        hold_done   = tick && (dur_cnt_q == dur_q - 8'd1);
        presc_clear = (state_q != StHold);
    end

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_evt_d    = cur_evt_q;
        pend_valid_d = pend_valid_q;
        pend_evt_d   = pend_evt_q;
        idx_d        = idx_q;
        tone_d       = tone_q;
        dur_d        = dur_q;
        dur_cnt_d    = '0;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A trigger coincident with done is not taken; it must be reasserted.
                if (trig_valid && !done_q && (trig_evt != EvReserved)) begin
                    cur_evt_d    = trig_evt;
                    idx_d        = 3'd0;
                    pend_valid_d = 1'b0;
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                cur_evt_d    = eff_evt;
                idx_d        = eff_idx;
                pend_valid_d = 1'b0;
                if ((eff_idx == 3'd4) || (note.dur_ms == 8'd0)) begin
                    state_d = StSilence;
                end else begin
                    tone_d  = tone_word(note.half_period);
                    dur_d   = note.dur_ms;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (wr_done) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                dur_cnt_d = tick ? dur_cnt_q + 8'd1 : dur_cnt_q;
                if (pend_valid_q) begin
                    state_d = StLoad;
                end else if (hold_done) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StLoad;
                end
            end
            StSilence: begin
                if (wr_done) begin
                    if (pend_valid_q) begin
                        state_d = StLoad;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (preempt) begin
            pend_valid_d = 1'b1;
            pend_evt_d   = trig_evt;
        end
    end

    always_comb begin
        busy           = (state_q != StIdle);
        done           = done_q;
        avm_write      = (state_q == StWrite) || (state_q == StSilence);
        avm_chipselect = avm_write;
        avm_writedata  = (state_q == StWrite) ? tone_q : TONE_SILENCE;
        avm_byteenable = avm_write ? 4'hF : 4'h0;
    end

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            cur_evt_q    <= EvHit;
            pend_evt_q   <= EvHit;
            pend_valid_q <= 1'b0;
            idx_q        <= '0;
            tone_q       <= TONE_SILENCE;
            dur_q        <= '0;
            dur_cnt_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            cur_evt_q    <= cur_evt_d;
            pend_evt_q   <= pend_evt_d;
            pend_valid_q <= pend_valid_d;
            idx_q        <= idx_d;
            tone_q       <= tone_d;
            dur_q        <= dur_d;
            dur_cnt_q    <= dur_cnt_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_audio_tone_master.sv
// Directed bench for audio_tone_master at DIV=10: single notes, stalled score sequence,
// preemption, dropped triggers, reserved code and asynchronous reset mid-write.
module tb_audio_tone_master;

    logic        clock50 = 1'b0;
    logic        reset = 1'b1;
    logic        trig_valid = 1'b0;
    logic [1:0]  trig_event = 2'd0;
    logic        busy, done, avm_chipselect, avm_write, avm_waitrequest;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int stall_n = 0;
    int ws_cnt = 0;
    int busy_gap = 0;
    int done_cnt = 0;
    int unstable = 0;

    logic        in_wr = 1'b0;
    int          wr_start = 0;
    logic [31:0] wr_data0 = 32'h0;
    logic [31:0] wr_data_q[$];
    int          wr_start_q[$];
    int          wr_len_q[$];

    int base, base2, cyc_trig, d0, u0;
    logic [31:0] exp_score [4];
    int          exp_gap [3];

    audio_tone_master #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clock50        (clock50),
        .reset          (reset),
        .trig_valid     (trig_valid),
        .trig_event     (trig_event),
        .busy           (busy),
        .done           (done),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clock50 = ~clock50;

    // Slave model: stall each write for stall_n cycles.
    assign avm_waitrequest = avm_write && (ws_cnt < stall_n);

    always @(posedge clock50) begin
        cyc    <= cyc + 1;
        ws_cnt <= (avm_write && avm_waitrequest) ? ws_cnt + 1 : 0;
    end

    // Transfer log: data, start cycle and length of every completed write.
    always @(negedge clock50) begin
        if (reset) begin
            in_wr <= 1'b0;
        end else if (avm_write) begin
            if (in_wr && ((avm_writedata !== wr_data0) || (avm_byteenable !== 4'hF))) begin
                unstable <= unstable + 1;
            end
            if (!avm_waitrequest) begin
                wr_data_q.push_back(avm_writedata);
                wr_start_q.push_back(in_wr ? wr_start : cyc);
                wr_len_q.push_back(in_wr ? cyc - wr_start + 1 : 1);
                in_wr <= 1'b0;
            end else if (!in_wr) begin
                in_wr    <= 1'b1;
                wr_start <= cyc;
                wr_data0 <= avm_writedata;
            end
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock50);
        #1;
    endtask

    task automatic trig(input logic [1:0] e);
        @(negedge clock50);
        trig_valid = 1'b1;
        trig_event = e;
        @(posedge clock50);
        #1;
        trig_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit got = 1'b0;
        busy_gap = 0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            if (done) got = 1'b1;
            else if (!busy) busy_gap++;
        end
        chk1({tag, "_done_seen"}, got, 1'b1);
    endtask

    function automatic int gap(input int i);
        return wr_start_q[i + 1] - (wr_start_q[i] + wr_len_q[i] - 1);
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_write"}, avm_write, 1'b0);
        chk1({tag, "_cs"}, avm_chipselect, 1'b0);
        chk({tag, "_data"}, avm_writedata, 32'h0);
        chk({tag, "_be"}, 32'(avm_byteenable), 32'h0);
    endtask

    initial begin
        exp_score = '{32'h8000_BAB9, 32'h8000_9430, 32'h8000_7C90, 32'h0000_0000};
        exp_gap   = '{802, 802, 1602};

        // Reset state
        repeat (3) step();
        chk_outputs_zero("reset");
        @(negedge clock50);
        reset = 1'b0;
        step();
        chk1("post_reset_idle", busy, 1'b0);

        // Hit, no wait states
        stall_n = 0;
        base = wr_data_q.size();
        d0 = done_cnt;
        trig(2'd0);
        cyc_trig = cyc;
        chk1("hit_busy_rise", busy, 1'b1);
        chk1("hit_load_no_write", avm_write, 1'b0);
        step();
        chk1("hit_write_k2", avm_write, 1'b1);
        chk1("hit_cs", avm_chipselect, 1'b1);
        chk("hit_data", avm_writedata, 32'h8000_DDF2);
        chk("hit_be", 32'(avm_byteenable), 32'hF);
        wait_done("hit", 400);
        chk("hit_done_cycle", 32'(cyc - cyc_trig), 32'd304);
        chk1("hit_busy_fall", busy, 1'b0);
        chk("hit_busy_span", 32'(busy_gap), 32'd0);
        step();
        chk1("hit_done_pulse_width", done, 1'b0);
        chk("hit_done_count", 32'(done_cnt - d0), 32'd1);
        chk("hit_nwrites", 32'(wr_data_q.size() - base), 32'd2);
        chk("hit_first_data", wr_data_q[base], 32'h8000_DDF2);
        chk("hit_first_len", 32'(wr_len_q[base]), 32'd1);
        chk("hit_first_start", 32'(wr_start_q[base] - cyc_trig), 32'd1);
        chk("hit_silence", wr_data_q[base + 1], 32'h0);
        chk("hit_gap", 32'(gap(base)), 32'd302);

        // Score, three wait states per write
        stall_n = 3;
        base = wr_data_q.size();
        d0 = done_cnt;
        u0 = unstable;
        trig(2'd2);
        wait_done("score", 5000);
        step();
        chk("score_nwrites", 32'(wr_data_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("score_data%0d", i), wr_data_q[base + i], exp_score[i]);
            chk($sformatf("score_len%0d", i), 32'(wr_len_q[base + i]), 32'd4);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("score_gap%0d", i), 32'(gap(base + i)), 32'(exp_gap[i]));
        end
        chk("score_stable", 32'(unstable - u0), 32'd0);
        chk("score_done_count", 32'(done_cnt - d0), 32'd1);

        // Hit preempted by wall during HOLD
        stall_n = 0;
        base = wr_data_q.size();
        d0 = done_cnt;
        trig(2'd0);
        repeat (52) step();
        trig(2'd1);
        cyc_trig = cyc;
        wait_done("preempt", 1000);
        step();
        chk("preempt_nwrites", 32'(wr_data_q.size() - base), 32'd3);
        chk("preempt_hit", wr_data_q[base], 32'h8000_DDF2);
        chk("preempt_wall", wr_data_q[base + 1], 32'h8001_BBE4);
        chk("preempt_latency", 32'(wr_start_q[base + 1] - cyc_trig), 32'd2);
        chk("preempt_silence", wr_data_q[base + 2], 32'h0);
        chk("preempt_gap", 32'(gap(base + 1)), 32'd402);
        chk("preempt_done_count", 32'(done_cnt - d0), 32'd1);

        // Score in progress: hit and wall are dropped
        base = wr_data_q.size();
        d0 = done_cnt;
        trig(2'd2);
        repeat (20) step();
        trig(2'd0);
        repeat (100) step();
        trig(2'd1);
        wait_done("drop", 5000);
        // Trigger coincident with done and not reasserted
        trig_valid = 1'b1;
        trig_event = 2'd0;
        step();
        trig_valid = 1'b0;
        chk1("done_cycle_trig_busy", busy, 1'b0);
        step();
        chk1("done_cycle_trig_write", avm_write, 1'b0);
        chk("drop_nwrites", 32'(wr_data_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drop_data%0d", i), wr_data_q[base + i], exp_score[i]);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drop_gap%0d", i), 32'(gap(base + i)), 32'(exp_gap[i]));
        end
        chk("drop_done_count", 32'(done_cnt - d0), 32'd1);

        // Reserved event code in IDLE
        base2 = wr_data_q.size();
        trig(2'd3);
        chk1("reserved_busy", busy, 1'b0);
        repeat (5) step();
        chk1("reserved_write", avm_write, 1'b0);
        chk("reserved_nwrites", 32'(wr_data_q.size() - base2), 32'd0);

        // Reset during a stalled write
        stall_n = 1000;
        trig(2'd0);
        step();
        chk1("stall_write_high", avm_write, 1'b1);
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        repeat (2) @(negedge clock50);
        reset = 1'b0;
        stall_n = 0;
        base = wr_data_q.size();
        d0 = done_cnt;
        trig(2'd0);
        step();
        chk1("replay_write", avm_write, 1'b1);
        chk("replay_data", avm_writedata, 32'h8000_DDF2);
        wait_done("replay", 400);
        step();
        chk("replay_nwrites", 32'(wr_data_q.size() - base), 32'd2);
        chk("replay_silence", wr_data_q[base + 1], 32'h0);
        chk("replay_done_count", 32'(done_cnt - d0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_tone_master.md
# audio_tone_master

Avalon-MM master that plays short tone sequences for game events (paddle hit, wall bounce, score) by issuing write transactions to the audio peripheral's Avalon slave port. It sits between the game logic and the system interconnect: game logic pulses an event code, and the block walks a fixed note table, writing one tone word per note and holding it for the note's duration. After the last note it writes silence.

## Interface
- `CLK_HZ`, default 50_000_000: `clock50` frequency.
- `TICK_HZ`, default 1000: duration tick rate (1 ms). `DIV = CLK_HZ/TICK_HZ`, integer, ≥ 2.
- `clock50`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `trig_valid`, input, 1: one-cycle event strobe.
- `trig_event`, input, 2: event code; 0 = hit, 1 = wall, 2 = score, 3 = reserved and ignored.
- `busy`, output, 1: high from trigger acceptance until the silence write completes.
- `done`, output, 1: one-cycle pulse on completion of the silence write.
- `avm_chipselect`, output, 1: equal to `avm_write`.
- `avm_write`, output, 1: write request.
- `avm_writedata`, output, 32: tone word.
- `avm_byteenable`, output, 4: always 4'hF while `avm_write` is high; 0 otherwise.
- `avm_waitrequest`, input, 1: slave stall.

## Operation
- Tone word format:
  - bit31 = enable.
  - bits19:0 = half-period in `clock50` cycles.
  - All other bits = 0.
  - Silence is 32'h0000_0000.
- Note table, as (event: half-period, duration ms), in order:
  - hit: 56818 (440 Hz), 30 ms.
  - wall: 113636 (220 Hz), 40 ms.
  - score: 47801, 80 ms; then 37936, 80 ms; then 31888, 160 ms.
  - Maximum 4 notes per event; an entry with duration 0 terminates the sequence.
- FSM states: IDLE, LOAD, WRITE, HOLD, SILENCE.
  - IDLE: on `trig_valid` with a valid event, latch the event, set note index to 0, go to LOAD.
  - LOAD: if the entry's duration is 0 or the index is 4, go to SILENCE. Otherwise register the tone word and duration, then go to WRITE.
  - WRITE: assert `avm_write` with the tone word. When `avm_waitrequest` = 0 the transfer completes; go to HOLD.
  - HOLD: count `duration*DIV` cycles, then increment the index and go to LOAD.
  - SILENCE: write 32'h0 with the same handshake as WRITE. On completion pulse `done` and go to IDLE.
- Preemption:
  - A trigger while busy whose priority is strictly higher than the current event's (score > wall > hit) is latched as pending. Equal or lower priority triggers are dropped.
  - A pending event is taken at the next LOAD entry, or immediately if the block is in HOLD. It restarts at note 0, and no silence write occurs between the two sequences.
  - A new pending trigger of higher priority overwrites an existing pending one.
- An in-flight write is never abandoned. `avm_address`/`avm_writedata` (the data only; there is no address port) and `avm_byteenable` stay stable while `avm_waitrequest` is high.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE, index is 0, pending is cleared, prescaler is 0.
- Reset asserted mid-write drops `avm_write` asynchronously. This is the accepted Avalon reset behaviour.
- Trigger sampled at edge k: LOAD occurs in cycle k+1, and `avm_write` is high from cycle k+2.
- A write with zero wait states lasts exactly 1 cycle. A write with `n` wait states lasts n+1 cycles.
- HOLD lasts exactly `duration*DIV` cycles. The prescaler is cleared on HOLD entry and is not free-running.
- Between consecutive notes there are 2 cycles of no write (HOLD exit to LOAD, then LOAD to WRITE).
- `busy` rises at k+1 and falls in the cycle after the silence transfer completes, coincident with `done`.
- If `trig_valid` arrives in the same cycle that `done` pulses, it is treated as an IDLE trigger on the next cycle only if it is reasserted. The busy-path priority rule applies to that cycle.

## Structure
- Package `audio_tone_pkg` contains:
  - The event code enum and priority function.
  - The note record typedef {half_period[19:0], dur_ms[7:0]}.
  - The constant note table of 3 events × 4 entries.
  - The tone word field positions and the silence constant.
- Sub-module `audio_ms_tick`: a prescaler with a clear input and a one-cycle `tick` output every `DIV` cycles. The duration counter in HOLD counts these ticks.

## Test plan
- CLK_HZ=1000, TICK_HZ=100 (DIV=10), `avm_waitrequest`=0, hit trigger:
  - 32'h8000_DDF2 is written at k+2.
  - 300 cycles later 32'h0 is written.
  - `done` pulses once and `busy` spans the whole sequence.
- Score trigger with waitrequest held high for 3 cycles on each write:
  - Writes occur in the order 32'h8000_BAB9, 32'h8000_9430, 32'h8000_7C90, 32'h0.
  - Each write's data is stable during its stall and each write lasts 4 cycles.
  - Hold times are 800, 800, and 1600 cycles.
- Hit in progress, wall trigger during HOLD:
  - 32'h8001_BBE4 is written within 2 cycles.
  - There is no silence write before it.
  - The sequence ends with a single 32'h0.
- Score in progress:
  - A hit or wall trigger is dropped and the score sequence is unchanged.
  - A trigger with event code 3 in IDLE leaves `busy` at 0 and produces no write.
- `reset` pulsed during a stalled WRITE:
  - `avm_write` drops asynchronously and all outputs are 0.
  - After release, a new hit trigger replays normally from note 0.
